alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares the single combinational RV32I ALU between two requesters (req0 = execute stage,
//   req1 = branch/address unit). Round-robin grant, registered ALU operand drive, captured
//   result returned on the winner's response channel with valid/ready handshake.
//   One operation in flight; sits between the requesters and the alu instance.
// PARAMETERS
//   XLEN   32  operand/result width
//   TAG_W  4   requester tag width, echoed unchanged on the response
// PORTS
//   clk                     in   1      clock, all state on rising edge
//   rst_n                   in   1      asynchronous reset, active low
//   req0_valid/req1_valid   in   1      request present
//   req0_ready/req1_ready   out  1      request accepted this cycle (combinational)
//   reqN_a, reqN_b          in   XLEN   operands
//   reqN_opcode             in   7      ALU opcode field
//   reqN_func3 / reqN_func7 in   3 / 7  ALU function fields
//   reqN_shamt              in   5      shift amount
//   reqN_tag                in   TAG_W  requester tag
//   rsp0_valid/rsp1_valid   out  1      result available
//   rsp0_ready/rsp1_ready   in   1      requester takes result
//   rspN_q                  out  XLEN   ALU result Q
//   rspN_eq/eqm/eqm_u       out  1      ALU EQ, EQM, EQM_U flags
//   rspN_tag                out  TAG_W  tag of the accepted request
//   alu_a, alu_b            out  XLEN   registered ALU operands
//   alu_opcode/func3/func7/shamt out 7/3/7/5 registered ALU controls
//   alu_q                   in   XLEN   ALU result
//   alu_eq/alu_eqm/alu_eqm_u in  1      ALU flags
// BEHAVIOUR
//   Reset: state IDLE, rr pointer = req0, reqN_ready=0 until IDLE evaluated, rspN_valid=0,
//     all alu_* outputs, rspN_q/flags/tag = 0. Reset mid-operation discards the op, no response.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: grant = only valid requester; both valid -> requester at rr pointer.
//     reqG_ready=1 only for grant; other ready=0. Handshake (valid&ready) latches operands,
//     controls, tag and owner into alu_* regs; rr pointer <= other requester; -> EXEC.
//     No valid -> stay IDLE, alu_* hold last values.
//   EXEC: ALU settles on registered inputs; at end of cycle alu_q/flags captured into owner's
//     rsp regs, rspOwner_valid <= 1 -> RESP. All reqN_ready=0.
//   RESP: rspOwner_valid=1, q/flags/tag stable until rspOwner_ready=1; then valid <= 0 -> IDLE.
//     Non-owner rsp_valid stays 0. All reqN_ready=0 (no acceptance during backpressure).
//   Latency: handshake in cycle N -> rsp_valid high in cycle N+2; min 3 cycles/op throughput.
//   Requesters hold valid and payload until ready; arbiter samples payload only at handshake.
//   Tag, q, flags passed bit-exact; no arithmetic performed in this block.
//   rr pointer only affects simultaneous requests; a lone requester wins every round.
// TESTING
//   1. rst_n=0 mid-run -> rsp0/1_valid=0, req ready=0 only while not IDLE, alu_a/alu_b=0.
//   2. req0 ADD A=1,B=2,tag=3 -> req0_ready same cycle; 2 cycles later rsp0_valid, q=3, tag=3.
//   3. req0 SUB 5-3 and req1 SLT A=-7,B=6 same cycle -> rsp0_q=2 first, then rsp1_q=1.
//   4. req0 held valid continuously, req1 idle -> req0 granted every 3 cycles, rsp1_valid=0.
//   5. rsp1_ready low 5 cycles after SLTU 2<3 -> rsp1_valid/q=1 stable, req0_ready=0; release.
//   6. rst_n low during EXEC -> rsp valid never rises, next request handled normally from IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC lets the ALU settle, RESP holds the result.
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [6:0]       req0_opcode,
  input  logic [2:0]       req0_func3,
  input  logic [6:0]       req0_func7,
  input  logic [4:0]       req0_shamt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [6:0]       req1_opcode,
  input  logic [2:0]       req1_func3,
  input  logic [6:0]       req1_func7,
  input  logic [4:0]       req1_shamt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_q,
  output logic             rsp0_eq,
  output logic             rsp0_eqm,
  output logic             rsp0_eqm_u,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_q,
  output logic             rsp1_eq,
  output logic             rsp1_eqm,
  output logic             rsp1_eqm_u,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  output logic [4:0]       alu_shamt,
  input  logic [XLEN-1:0]  alu_q,
  input  logic             alu_eq,
  input  logic             alu_eqm,
  input  logic             alu_eqm_u
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [4:0]       shamt;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t           state_reg, state_next;
  logic             rr_reg, rr_next;
  logic             owner_reg, owner_next;
  logic             grant;
  logic             load, capture, retire;
  logic [1:0]       req_valid, req_ready, rsp_ready;
  req_t [1:0]       req_pl;
  req_t             sel_pl;

  logic [XLEN-1:0]  alu_a_reg, alu_b_reg;
  logic [6:0]       alu_opcode_reg, alu_func7_reg;
  logic [2:0]       alu_func3_reg;
  logic [4:0]       alu_shamt_reg;
  logic [TAG_W-1:0] op_tag_reg;

  logic [1:0]                  rsp_valid_vec;
  logic [1:0][XLEN-1:0]        rsp_q_vec;
  logic [1:0][2:0]             rsp_flag_vec;
  logic [1:0][TAG_W-1:0]       rsp_tag_vec;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_pl[0] = {req0_a, req0_b, req0_opcode, req0_func3, req0_func7, req0_shamt, req0_tag};
  assign req_pl[1] = {req1_a, req1_b, req1_opcode, req1_func3, req1_func7, req1_shamt, req1_tag};

  // The rr pointer only breaks ties; a lone requester always wins.
  assign grant  = (&req_valid) ? rr_reg : req_valid[1];
  assign sel_pl = req_pl[grant];

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    owner_next = owner_reg;
    req_ready  = 2'b00;
    load       = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          load             = 1'b1;
          owner_next       = grant;
          rr_next          = ~grant;
          state_next       = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_reg]) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_reg         <= 1'b0;
      owner_reg      <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      alu_func3_reg  <= '0;
      alu_func7_reg  <= '0;
      alu_shamt_reg  <= '0;
      op_tag_reg     <= '0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      owner_reg <= owner_next;
      if (load) begin
        alu_a_reg      <= sel_pl.a;
        alu_b_reg      <= sel_pl.b;
        alu_opcode_reg <= sel_pl.opcode;
        alu_func3_reg  <= sel_pl.func3;
        alu_func7_reg  <= sel_pl.func7;
        alu_shamt_reg  <= sel_pl.shamt;
        op_tag_reg     <= sel_pl.tag;
      end
    end
  end

  // Per-requester response channel; only the owner's copy ever changes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      localparam logic IDX = 1'(gi);
      logic             valid_reg;
      logic [XLEN-1:0]  q_reg;
      logic [2:0]       flag_reg;
      logic [TAG_W-1:0] rsp_tag_reg;
      logic             mine;

      assign mine = (owner_reg == IDX);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg   <= 1'b0;
          q_reg       <= '0;
          flag_reg    <= '0;
          rsp_tag_reg <= '0;
        end else if (capture && mine) begin
          valid_reg   <= 1'b1;
          q_reg       <= alu_q;
          flag_reg    <= {alu_eq, alu_eqm, alu_eqm_u};
          rsp_tag_reg <= op_tag_reg;
        end else if (retire && mine) begin
          valid_reg <= 1'b0;
        end
      end

      assign rsp_valid_vec[gi] = valid_reg;
      assign rsp_q_vec[gi]     = q_reg;
      assign rsp_flag_vec[gi]  = flag_reg;
      assign rsp_tag_vec[gi]   = rsp_tag_reg;
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp0_q     = rsp_q_vec[0];
  assign rsp0_eq    = rsp_flag_vec[0][2];
  assign rsp0_eqm   = rsp_flag_vec[0][1];
  assign rsp0_eqm_u = rsp_flag_vec[0][0];
  assign rsp0_tag   = rsp_tag_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp1_q     = rsp_q_vec[1];
  assign rsp1_eq    = rsp_flag_vec[1][2];
  assign rsp1_eqm   = rsp_flag_vec[1][1];
  assign rsp1_eqm_u = rsp_flag_vec[1][0];
  assign rsp1_tag   = rsp_tag_vec[1];

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_opcode = alu_opcode_reg;
  assign alu_func3  = alu_func3_reg;
  assign alu_func7  = alu_func7_reg;
  assign alu_shamt  = alu_shamt_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, vector table plus multi-cycle sequences,
// response scoreboard in expected grant order.
module tb_alu_arbiter;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] F7_S  = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [6:0]  req0_opcode, req0_func7, req1_opcode, req1_func7;
  logic [2:0]  req0_func3, req1_func3;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_q, rsp1_q;
  logic        rsp0_eq, rsp0_eqm, rsp0_eqm_u, rsp1_eq, rsp1_eqm, rsp1_eqm_u;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic [31:0] alu_a, alu_b, alu_q;
  logic [6:0]  alu_opcode, alu_func7;
  logic [2:0]  alu_func3;
  logic [4:0]  alu_shamt;
  logic        alu_eq, alu_eqm, alu_eqm_u;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        ch;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [2:0]  fl;   // {eq, eqm, eqm_u}
  } vec_t;

  vec_t sb[$];

  alu_arbiter #(.XLEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_opcode(req0_opcode), .req0_func3(req0_func3), .req0_func7(req0_func7),
    .req0_shamt(req0_shamt), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_opcode(req1_opcode), .req1_func3(req1_func3), .req1_func7(req1_func7),
    .req1_shamt(req1_shamt), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_q(rsp0_q), .rsp0_eq(rsp0_eq),
    .rsp0_eqm(rsp0_eqm), .rsp0_eqm_u(rsp0_eqm_u), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_q(rsp1_q), .rsp1_eq(rsp1_eq),
    .rsp1_eqm(rsp1_eqm), .rsp1_eqm_u(rsp1_eqm_u), .rsp1_tag(rsp1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_func3(alu_func3),
    .alu_func7(alu_func7), .alu_shamt(alu_shamt),
    .alu_q(alu_q), .alu_eq(alu_eq), .alu_eqm(alu_eqm), .alu_eqm_u(alu_eqm_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared ALU, fed from the arbiter's registered operands.
  always_comb begin
    alu_q = alu_a + alu_b;
    if (alu_opcode == OP_R) begin
      case (alu_func3)
        3'd0: alu_q = alu_func7[5] ? alu_a - alu_b : alu_a + alu_b;
        3'd1: alu_q = alu_a << alu_b[4:0];
        3'd2: alu_q = {31'b0, $signed(alu_a) < $signed(alu_b)};
        3'd3: alu_q = {31'b0, alu_a < alu_b};
        3'd4: alu_q = alu_a ^ alu_b;
        3'd5: alu_q = alu_func7[5] ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
        3'd6: alu_q = alu_a | alu_b;
        default: alu_q = alu_a & alu_b;
      endcase
    end else if (alu_opcode == OP_I && alu_func3 == 3'd1) begin
      alu_q = alu_a << alu_shamt;
    end
  end
  assign alu_eq    = (alu_a == alu_b);
  assign alu_eqm   = ($signed(alu_a) < $signed(alu_b));
  assign alu_eqm_u = (alu_a < alu_b);

  function automatic vec_t mk(input logic ch, input logic [31:0] a, input logic [31:0] b,
                              input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] sh, input logic [3:0] tag,
                              input logic [31:0] q, input logic [2:0] fl);
    vec_t v;
    v.ch = ch; v.a = a; v.b = b; v.op = op; v.f3 = f3; v.f7 = f7;
    v.sh = sh; v.tag = tag; v.q = q; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    if (v.ch == 1'b0) begin
      req0_valid = vld; req0_a = v.a; req0_b = v.b; req0_opcode = v.op;
      req0_func3 = v.f3; req0_func7 = v.f7; req0_shamt = v.sh; req0_tag = v.tag;
    end else begin
      req1_valid = vld; req1_a = v.a; req1_b = v.b; req1_opcode = v.op;
      req1_func3 = v.f3; req1_func7 = v.f7; req1_shamt = v.sh; req1_tag = v.tag;
    end
  endtask

  function automatic logic rdy(input logic ch);
    return ch ? req1_ready : req0_ready;
  endfunction

  // Present a request at a falling edge and hold it until accepted.
  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clk);
    drive(v, 1'b1);
    #1;
    while (!rdy(v.ch) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy(v.ch)) begin
      total++; bad++;
      $display("FAIL send_timeout ch%0d actual=ready_low required=ready_high", v.ch);
      drive(v, 1'b0);
    end else begin
      @(posedge clk);
      #1;
      drive(v, 1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic take(input logic ch, input logic [31:0] q, input logic [3:0] tag,
                      input logic [2:0] fl);
    vec_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL rsp_unexpected actual=ch%0d_q%h required=no_response", ch, q);
    end else begin
      e = sb.pop_front();
      $display("rsp ch%0d q=%h tag=%h flags=%b", ch, q, tag, fl);
      chk("rsp_channel", 32'(ch), 32'(e.ch));
      chk("rsp_q", q, e.q);
      chk("rsp_tag", 32'(tag), 32'(e.tag));
      chk("rsp_flags", 32'(fl), 32'(e.fl));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp1_valid) begin
        total++; bad++;
        $display("FAIL rsp_both_valid actual=2 required=1");
      end
      if (rsp0_valid && rsp0_ready) take(1'b0, rsp0_q, rsp0_tag, {rsp0_eq, rsp0_eqm, rsp0_eqm_u});
      if (rsp1_valid && rsp1_ready) take(1'b1, rsp1_q, rsp1_tag, {rsp1_eq, rsp1_eqm, rsp1_eqm_u});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    vec_t v, v0, v1;
    int   n, last;

    tbl[0] = mk(1'b0, 32'd1,          32'd2,          OP_R, 3'd0, 7'd0, 5'd0,  4'h3, 32'd3,          3'b011);
    tbl[1] = mk(1'b1, 32'd10,         32'd10,         OP_R, 3'd0, F7_S, 5'd0,  4'h5, 32'd0,          3'b100);
    tbl[2] = mk(1'b0, 32'hF0F0_0000,  32'h0FF0_FFFF,  OP_R, 3'd4, 7'd0, 5'd0,  4'h7, 32'hFF00_FFFF,  3'b010);
    tbl[3] = mk(1'b1, 32'hFFFF_0000,  32'h1234_5678,  OP_R, 3'd7, 7'd0, 5'd0,  4'hF, 32'h1234_0000,  3'b010);
    tbl[4] = mk(1'b0, 32'd1,          32'd0,          OP_I, 3'd1, 7'd0, 5'd31, 4'h1, 32'h8000_0000,  3'b000);
    tbl[5] = mk(1'b1, 32'h8000_0000,  32'd4,          OP_R, 3'd5, F7_S, 5'd0,  4'h2, 32'hF800_0000,  3'b010);
    tbl[6] = mk(1'b0, 32'hFFFF_FFF9,  32'd6,          OP_R, 3'd2, 7'd0, 5'd0,  4'h4, 32'd1,          3'b010);
    tbl[7] = mk(1'b1, 32'hFFFF_FFF9,  32'd6,          OP_R, 3'd3, 7'd0, 5'd0,  4'h8, 32'd0,          3'b010);
    tbl[8] = mk(1'b0, 32'd0,          32'd0,          OP_R, 3'd6, 7'd0, 5'd0,  4'hA, 32'd0,          3'b100);

    rst_n = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    v = mk(1'b0, 0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 4'd0, 0, 3'd0);
    drive(v, 1'b0);
    v.ch = 1'b1;
    drive(v, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("reset_rsp0_q", rsp0_q, 32'd0);
    chk("reset_rsp1_tag", 32'(rsp1_tag), 32'd0);
    rst_n = 1'b1;

    // ADD with latency check: handshake in cycle N, response valid in N+2
    sb.push_back(tbl[0]);
    @(negedge clk);
    drive(tbl[0], 1'b1);
    #1;
    chk("t2_ready_same_cycle", 32'(req0_ready), 32'd1);
    chk("t2_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    drive(tbl[0], 1'b0);
    @(negedge clk);
    chk("t2_valid_n1", 32'(rsp0_valid), 32'd0);
    @(negedge clk);
    chk("t2_valid_n2", 32'(rsp0_valid), 32'd1);
    drain();

    // Lone requests from the vector table
    for (int i = 1; i < 9; i++) begin
      sb.push_back(tbl[i]);
      send(tbl[i]);
      drain();
    end

    // Simultaneous requests after reset: rr pointer starts at req0
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = mk(1'b0, 32'd5,         32'd3, OP_R, 3'd0, F7_S, 5'd0, 4'h4, 32'd2, 3'b000);
    v1 = mk(1'b1, 32'hFFFF_FFF9, 32'd6, OP_R, 3'd2, 7'd0, 5'd0, 4'h9, 32'd1, 3'b010);
    sb.push_back(v0);
    sb.push_back(v1);
    fork
      send(v0);
      send(v1);
      begin
        @(negedge clk);
        #2;
        chk("t3_req0_ready", 32'(req0_ready), 32'd1);
        chk("t3_req1_ready", 32'(req1_ready), 32'd0);
      end
    join
    drain();

    // req0 held valid continuously: grant every 3 cycles, req1 response stays idle
    v = mk(1'b0, 32'd100, 32'd0, OP_R, 3'd0, 7'd0, 5'd0, 4'h0, 32'd100, 3'b000);
    last = 0;
    @(negedge clk);
    drive(v, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!req0_ready && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!req0_ready) begin
        total++; bad++;
        $display("FAIL t4_grant_timeout actual=ready_low required=ready_high");
        break;
      end
      if (k > 0) chk("t4_interval", 32'(cyc - last), 32'd3);
      last = cyc;
      chk("t4_rsp1_idle", 32'(rsp1_valid), 32'd0);
      sb.push_back(v);
      @(posedge clk);
      #1;
      v.b = 32'(k + 1);
      v.tag = 4'(k + 1);
      v.q = 32'(101 + k);
      drive(v, 1'b1);
      @(negedge clk);
    end
    drive(v, 1'b0);
    drain();

    // Backpressure on rsp1 while req0 waits
    @(posedge clk);
    #1;
    rsp1_ready = 1'b0;
    v1 = mk(1'b1, 32'd2, 32'd3, OP_R, 3'd3, 7'd0, 5'd0, 4'h6, 32'd1,  3'b011);
    v0 = mk(1'b0, 32'd7, 32'd8, OP_R, 3'd0, 7'd0, 5'd0, 4'hC, 32'd15, 3'b011);
    sb.push_back(v1);
    sb.push_back(v0);
    send(v1);
    @(negedge clk);
    drive(v0, 1'b1);
    n = 0;
    while (!rsp1_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      #1;
      chk("t5_rsp1_valid_held", 32'(rsp1_valid), 32'd1);
      chk("t5_rsp1_q_held", rsp1_q, 32'd1);
      chk("t5_req0_blocked", 32'(req0_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp1_ready = 1'b1;
    n = 0;
    @(negedge clk);
    #1;
    while (!req0_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req0_ready) begin
      total++; bad++;
      $display("FAIL t5_req0_timeout actual=ready_low required=ready_high");
    end
    @(posedge clk);
    #1;
    drive(v0, 1'b0);
    drain();

    // Reset while the operation is in EXEC: no response, then normal service
    v = mk(1'b0, 32'h55, 32'hAA, OP_R, 3'd0, 7'd0, 5'd0, 4'h3, 32'hFF, 3'b011);
    @(negedge clk);
    drive(v, 1'b1);
    #1;
    chk("t6_ready", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(v, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_alu_a_cleared", alu_a, 32'd0);
    chk("t6_alu_b_cleared", alu_b, 32'd0);
    chk("t6_rsp0_valid_rst", 32'(rsp0_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_rsp0", 32'(rsp0_valid), 32'd0);
    end
    v = mk(1'b1, 32'hFFFF_FFFF, 32'd1, OP_R, 3'd0, 7'd0, 5'd0, 4'h9, 32'd0, 3'b010);
    sb.push_back(v);
    send(v);
    drain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
